// File: rtl/pio_blink_pkg.sv
// pio_blink_pkg
//   Register word offsets and STATUS bit positions shared by the blinking
//   parallel output port and anything that talks to it.
package pio_blink_pkg;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_RSVD     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR   = 3'd5;
    localparam logic [2:0] ADDR_OUTTGL   = 3'd6;
    localparam logic [2:0] ADDR_STATUS   = 3'd7;

    localparam int STATUS_PHASE_BIT = 0;
    localparam int STATUS_PNZ_BIT   = 1;

endpackage

// File: rtl/blink_timer.sv
// blink_timer
//   Free-running half-period timer. The counter runs 0..period and the phase
//   flips on every wrap, giving a half-period of period+1 cycles.
//   Ports:
//     clk      - clock, rising edge
//     reset    - synchronous, active-high
//     period   - wrap value; zero parks the timer with phase low
//     restart  - clears counter and phase (used on PERIOD writes)
//     phase    - current blink phase (registered)
module blink_timer #(
    parameter int PERIOD_W = 26
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PERIOD_W-1:0] period,
    input  logic                restart,
    output logic                phase
);

    logic [PERIOD_W-1:0] cnt_q, cnt_d;
    logic                phase_q, phase_d;

    always_comb begin
        cnt_d   = cnt_q;
        phase_d = phase_q;
        // restart wins over a wrap landing on the same edge
        if (restart || (period == '0)) begin
            cnt_d   = '0;
            phase_d = 1'b0;
        end else if (cnt_q == period) begin
            cnt_d   = '0;
            phase_d = ~phase_q;
        end else begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q   <= '0;
            phase_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            phase_q <= phase_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: rtl/pio_blink_out.sv
// pio_blink_out
//   Memory-mapped parallel output port with per-bit blinking. Bits enabled in
//   BLINK_EN are gated off while the blink phase is high; other bits follow
//   DATA. OUTSET/OUTCLR/OUTTGL give atomic bit manipulation of DATA.
//   Ports:
//     clk, reset  - clock and synchronous active-high reset
//     address     - register word offset
//     chipselect  - slave select
//     write_n     - active-low write strobe (qualified by chipselect)
//     writedata   - write data
//     readdata    - combinational read data for the current address
//     out_port    - registered pin drive
module pio_blink_out
    import pio_blink_pkg::*;
#(
    parameter int               WIDTH       = 18,
    parameter int               PERIOD_W    = 26,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]    data_q, data_d;
    logic [WIDTH-1:0]    blink_en_q, blink_en_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [WIDTH-1:0]    out_port_q, out_port_d;

    logic                wr_en;
    logic                period_restart;
    logic                phase;
    logic [WIDTH-1:0]    wdata_w;
    logic [PERIOD_W-1:0] wdata_p;
    logic                unused_wdata;

    assign wr_en          = chipselect & ~write_n;
    assign period_restart = wr_en && (address == ADDR_PERIOD);
    assign wdata_w        = writedata[WIDTH-1:0];
    assign wdata_p        = writedata[PERIOD_W-1:0];
    // upper write bits beyond the register widths are intentionally dropped
    assign unused_wdata   = ^writedata;

    always_comb begin
        data_d     = data_q;
        blink_en_d = blink_en_q;
        period_d   = period_q;
        if (wr_en) begin
            case (address)
                ADDR_DATA:     data_d     = wdata_w;
                ADDR_BLINK_EN: blink_en_d = wdata_w;
                ADDR_PERIOD:   period_d   = wdata_p;
                ADDR_OUTSET:   data_d     = data_q | wdata_w;
                ADDR_OUTCLR:   data_d     = data_q & ~wdata_w;
                ADDR_OUTTGL:   data_d     = data_q ^ wdata_w;
                default:       ;  // reserved and STATUS ignore writes
            endcase
        end
    end

    // pin drive uses the pre-edge register state, hence the one-cycle lag
    // after both register writes and phase changes
    assign out_port_d = data_q & ~(blink_en_q & {WIDTH{phase}});

    always_ff @(posedge clk) begin
        if (reset) begin
            data_q     <= RESET_VALUE;
            blink_en_q <= '0;
            period_q   <= '0;
            out_port_q <= RESET_VALUE;
        end else begin
            data_q     <= data_d;
            blink_en_q <= blink_en_d;
            period_q   <= period_d;
            out_port_q <= out_port_d;
        end
    end

    blink_timer #(
        .PERIOD_W (PERIOD_W)
    ) u_timer (
        .clk     (clk),
        .reset   (reset),
        .period  (period_q),
        .restart (period_restart),
        .phase   (phase)
    );

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata = 32'(data_q);
            ADDR_BLINK_EN: readdata = 32'(blink_en_q);
            ADDR_PERIOD:   readdata = 32'(period_q);
            ADDR_STATUS: begin
                readdata[STATUS_PHASE_BIT] = phase;
                readdata[STATUS_PNZ_BIT]   = |period_q;
            end
            default:       readdata = '0;
        endcase
    end

    assign out_port = out_port_q;

endmodule

// File: tb/tb_pio_blink_out.sv
// Directed bench with a scoreboard: stimulus pushes (due-cycle, signal,
// expected) entries; a negedge monitor pops and checks them.
module tb_pio_blink_out;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset;
    logic [2:0]  address;
    logic        cs_a, cs_b, write_n;
    logic [31:0] writedata;
    logic [31:0] rd_a, rd_b;
    logic [17:0] out_a;
    logic [31:0] out_b;

    pio_blink_out #(
        .WIDTH       (18),
        .PERIOD_W    (26),
        .RESET_VALUE (18'h00055)
    ) dut_a (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (cs_a),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd_a),
        .out_port   (out_a)
    );

    pio_blink_out #(
        .WIDTH       (32),
        .PERIOD_W    (1),
        .RESET_VALUE (32'h0)
    ) dut_b (
        .clk        (clk),
        .reset      (reset),
        .address    (address),
        .chipselect (cs_b),
        .write_n    (write_n),
        .writedata  (writedata),
        .readdata   (rd_b),
        .out_port   (out_b)
    );

    // sig: 0 out_a, 1 rd_a, 2 out_b, 3 rd_b
    typedef struct {
        int          due;
        int          sig;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    int   cyc   = 0;
    int   n_cmp = 0;
    int   n_bad = 0;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic void expect_at(int due, int sig, logic [31:0] exp, string name);
        exp_t e;
        e.due  = due;
        e.sig  = sig;
        e.exp  = exp;
        e.name = name;
        sb_q.push_back(e);
    endfunction

    function automatic logic [31:0] sample(int sig);
        case (sig)
            0:       return 32'(out_a);
            1:       return rd_a;
            2:       return out_b;
            default: return rd_b;
        endcase
    endfunction

    // monitor
    always @(negedge clk) begin
        int i;
        logic [31:0] act;
        i = 0;
        while (i < sb_q.size()) begin
            if (sb_q[i].due <= cyc) begin
                act = sample(sb_q[i].sig);
                n_cmp++;
                if (act !== sb_q[i].exp) begin
                    n_bad++;
                    $display("FAIL %s cyc=%0d got=%h expected=%h", sb_q[i].name, cyc, act, sb_q[i].exp);
                end else begin
                    $display("ok   %s cyc=%0d value=%h", sb_q[i].name, cyc, act);
                end
                sb_q.delete(i);
            end else begin
                i++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic bus_write(input bit to_b, input logic [2:0] a, input logic [31:0] d);
        cs_a      = !to_b;
        cs_b      = to_b;
        write_n   = 1'b0;
        address   = a;
        writedata = d;
        tick();
        cs_a      = 1'b0;
        cs_b      = 1'b0;
        write_n   = 1'b1;
    endtask

    // write, then check out_port keeps its old value this cycle and takes the new one next
    task automatic wr_chk(input bit to_b, input logic [2:0] a, input logic [31:0] d,
                          input logic [31:0] old_v, input logic [31:0] new_v, input string name);
        bus_write(to_b, a, d);
        expect_at(cyc,     to_b ? 2 : 0, old_v, {name, "_out_old"});
        expect_at(cyc + 1, to_b ? 2 : 0, new_v, {name, "_out_new"});
    endtask

    task automatic rd(input bit to_b, input logic [2:0] a, input logic [31:0] exp, input string name);
        cs_a    = !to_b;
        cs_b    = to_b;
        write_n = 1'b1;
        address = a;
        expect_at(cyc, to_b ? 3 : 1, exp, name);
        tick();
        cs_a    = 1'b0;
        cs_b    = 1'b0;
    endtask

    // called right after a PERIOD write edge: phase is 0 at j=0 and flips every hp cycles;
    // out_port lags phase by one cycle
    task automatic blink_check(input bit to_b, input int hp, input int n,
                               input logic [31:0] data, input logic [31:0] blink, input string name);
        int          ph_now;
        int          ph_prev;
        logic [31:0] gate;
        address = 3'd7;
        for (int j = 0; j < n; j++) begin
            ph_now  = (j / hp) % 2;
            ph_prev = (j == 0) ? 0 : ((j - 1) / hp) % 2;
            gate    = (ph_prev != 0) ? blink : 32'h0;
            expect_at(cyc + j, to_b ? 3 : 1, 32'h2 | 32'(ph_now), $sformatf("%s_status%0d", name, j));
            expect_at(cyc + j, to_b ? 2 : 0, data & ~gate,        $sformatf("%s_out%0d", name, j));
        end
        repeat (n) tick();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset     = 1'b1;
        cs_a      = 1'b0;
        cs_b      = 1'b0;
        write_n   = 1'b1;
        address   = 3'd0;
        writedata = 32'h0;
        repeat (3) tick();
        reset = 1'b0;

        n_cmp++;
        if (out_a !== 18'h00055) begin
            n_bad++;
            $display("FAIL direct_rst_out_a got=%h expected=%h", out_a, 18'h00055);
        end else begin
            $display("ok   direct_rst_out_a value=%h", out_a);
        end
        n_cmp++;
        if (out_b !== 32'h0) begin
            n_bad++;
            $display("FAIL direct_rst_out_b got=%h expected=%h", out_b, 32'h0);
        end else begin
            $display("ok   direct_rst_out_b value=%h", out_b);
        end

        // reset state
        expect_at(cyc, 0, 32'h55, "rst_out_a");
        expect_at(cyc, 2, 32'h0,  "rst_out_b");
        rd(0, 3'd0, 32'h55, "rst_data");
        rd(0, 3'd1, 32'h0,  "rst_blink_en");
        rd(0, 3'd2, 32'h0,  "rst_period");
        rd(0, 3'd7, 32'h0,  "rst_status");

        // set/clear/toggle: F0 | 00F = FF; FF & ~030 = CF; CF ^ 101 = 1CE
        wr_chk(0, 3'd0, 32'h0F0, 32'h55, 32'h0F0, "wr_data");
        wr_chk(0, 3'd4, 32'h00F, 32'h0F0, 32'h0FF, "outset");
        wr_chk(0, 3'd5, 32'h030, 32'h0FF, 32'h0CF, "outclr");
        wr_chk(0, 3'd6, 32'h101, 32'h0CF, 32'h1CE, "outtgl");
        rd(0, 3'd0, 32'h1CE, "data_after_bitops");

        n_cmp++;
        if (out_a !== 18'h001CE) begin
            n_bad++;
            $display("FAIL direct_bitops_out got=%h expected=%h", out_a, 18'h001CE);
        end else begin
            $display("ok   direct_bitops_out value=%h", out_a);
        end

        // blinking, PERIOD=4 -> half-period 5; upper writedata bits dropped
        wr_chk(0, 3'd0, 32'hFFFF_FFFF, 32'h1CE, 32'h3FFFF, "wr_data_all");
        wr_chk(0, 3'd1, 32'h0000_0003, 32'h3FFFF, 32'h3FFFF, "wr_blink_en");
        bus_write(0, 3'd2, 32'h4);
        blink_check(0, 5, 15, 32'h3FFFF, 32'h3, "blink5");

        // at cyc P+15 cnt=0 phase=1; cnt reaches 4 with phase 0 after edge P+24
        repeat (9) tick();
        bus_write(0, 3'd2, 32'h2);
        blink_check(0, 3, 9, 32'h3FFFF, 32'h3, "blink3");

        // phase is 1 here; reset with coincident OUTSET of bit 9
        reset     = 1'b1;
        cs_a      = 1'b1;
        write_n   = 1'b0;
        address   = 3'd4;
        writedata = 32'h200;
        tick();
        reset     = 1'b0;
        cs_a      = 1'b0;
        write_n   = 1'b1;

        n_cmp++;
        if (out_a !== 18'h00055) begin
            n_bad++;
            $display("FAIL direct_midrst_out got=%h expected=%h", out_a, 18'h00055);
        end else begin
            $display("ok   direct_midrst_out value=%h", out_a);
        end

        expect_at(cyc, 0, 32'h55, "midrst_out");
        rd(0, 3'd7, 32'h0,  "midrst_status");
        rd(0, 3'd0, 32'h55, "midrst_data");
        rd(0, 3'd1, 32'h0,  "midrst_blink_en");
        rd(0, 3'd2, 32'h0,  "midrst_period");
        repeat (6) tick();
        expect_at(cyc, 0, 32'h55, "midrst_out_later");
        rd(0, 3'd7, 32'h0, "midrst_status_later");

        // writes to reserved and STATUS are ignored; offsets 3..6 read 0
        bus_write(0, 3'd3, 32'hFFFF_FFFF);
        bus_write(0, 3'd7, 32'hFFFF_FFFF);
        expect_at(cyc + 1, 0, 32'h55, "ign_out");
        rd(0, 3'd0, 32'h55, "ign_data");
        rd(0, 3'd1, 32'h0,  "ign_blink_en");
        rd(0, 3'd2, 32'h0,  "ign_period");
        rd(0, 3'd7, 32'h0,  "ign_status");
        for (int a = 3; a <= 6; a++) rd(0, 3'(a), 32'h0, $sformatf("rd_zero_off%0d", a));

        // WIDTH=32, PERIOD_W=1: PERIOD=1 gives a 2-cycle half-period
        wr_chk(1, 3'd0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, "b_wr_data");
        bus_write(1, 3'd1, 32'h8000_0001);
        bus_write(1, 3'd2, 32'hFFFF_FFFF);
        blink_check(1, 2, 8, 32'hFFFF_FFFF, 32'h8000_0001, "b_blink2");
        rd(1, 3'd2, 32'h1,         "b_period");
        rd(1, 3'd0, 32'hFFFF_FFFF, "b_data");
        rd(1, 3'd1, 32'h8000_0001, "b_blink_en");

        for (int k = 0; k < 50 && sb_q.size() > 0; k++) tick();
        while (sb_q.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s never checked (due cyc %0d)", sb_q[0].name, sb_q[0].due);
            sb_q.delete(0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
